// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock enable, h/v counters, sync/blank flags
// and a short delay line that aligns control with the registered RGB path.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_ce,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       blank_n_d
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [2:0] DIV_MAX  = 3'(CLK_DIV - 1);
  localparam logic [2:0] DIV_HALF = 3'(CLK_DIV / 2);
  localparam logic       DIV_GT1  = (CLK_DIV > 1);

  logic [2:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       pix_ce_q;
  logic       vga_clk_q;
  logic       hs_q;
  logic       vs_q;
  logic       von_q;
  logic       fs_q;
  logic       wrap;

  always_comb begin
    div_d = (div_q == DIV_MAX) ? 3'd0 : div_q + 3'd1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_ce_q) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  assign wrap = pix_ce_q && (h_q == H_LAST) && (v_q == V_LAST);

  // Flags decode the next counter values so they land aligned with x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 3'd0;
      pix_ce_q  <= 1'b0;
      vga_clk_q <= 1'b0;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      von_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      pix_ce_q  <= (div_d == DIV_MAX);
      vga_clk_q <= DIV_GT1 && (div_d >= DIV_HALF);
      h_q       <= h_d;
      v_q       <= v_d;
      fs_q      <= wrap;
      if (pix_ce_q) begin
        hs_q  <= !((h_d >= HS_START) && (h_d < HS_END));
        vs_q  <= !((v_d >= VS_START) && (v_d < VS_END));
        von_q <= (h_d < H_ACT) && (v_d < V_ACT);
      end
    end
  end

  assign x           = h_q;
  assign y           = v_q;
  assign pix_ce      = pix_ce_q;
  assign vga_clk     = vga_clk_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = von_q;
  assign frame_start = fs_q;

  generate
    if (PIPE_DELAY == 0) begin : g_wire
      assign hsync_d   = hs_q;
      assign vsync_d   = vs_q;
      assign blank_n_d = von_q;
    end else begin : g_pipe
      logic [2:0] sr_q [PIPE_DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DELAY; i++)
            sr_q[i] <= 3'b110;
        end else begin
          sr_q[0] <= {hs_q, vs_q, von_q};
          for (int i = 1; i < PIPE_DELAY; i++)
            sr_q[i] <= sr_q[i-1];
        end
      end

      assign {hsync_d, vsync_d, blank_n_d} = sr_q[PIPE_DELAY-1];
    end
  endgenerate

endmodule
